serializer16: RTL and testbench

Parallel-in / serial-out converter for 16-bit Hack words: accepts one word over a valid/ready handshake and emits it one bit per accepted beat on a serial valid/ready stream, with first/last markers. It is the transmit end of the bit-serial word link. The paired deserializer rebuilds words from this stream. It sits between word-wide datapath logic (ALU, registers, the `*16_gate` family) and any 1-bit channel.

---
 rtl/serializer16_pkg.sv | 16 +
 rtl/shift_reg16.sv | 30 +++
 rtl/serializer16.sv | 101 ++++++++++
 tb/tb_serializer16.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serializer16_pkg.sv
// Shared definitions for the bit-serial word link (serializer and deserializer).
package serializer16_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int CNT_WIDTH  = 4;

  // Index of the final bit of a word, as held in the bit counter.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WORD_WIDTH - 1);

  // Link state encoding, shared with the deserializer.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/shift_reg16.sv
// 16-bit shift register: parallel load, one-position shift toward the output end.
module shift_reg16
  import serializer16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] in,
  output logic [WORD_WIDTH-1:0] q
);

  // Load beats shift; shifting moves bits toward the serial output end and zero-fills.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: this register is reset even though the gated output never exposes stale data, so a
  // reset always leaves the datapath in a known state for debug and equivalence checking.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= in;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WORD_WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WORD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serializer16.sv
// Parallel-in / serial-out converter for 16-bit words with first/last markers.
module serializer16
  import serializer16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last
);

  // Selects the shift-register bit that sits at the serial output end.
  localparam logic [WORD_WIDTH-1:0] OUT_MASK =
    MSB_FIRST ? (WORD_WIDTH'(1) << (WORD_WIDTH - 1)) : WORD_WIDTH'(1);

  ser_state_t           state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 load, shift;
  logic [WORD_WIDTH-1:0] shreg;

  shift_reg16 #(
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .in   (in),
    .q    (shreg)
  );

  // State and bit-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SER_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and handshake decode; everything is forced low while reset is held.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    shift      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    if (!reset) begin
      unique case (state)
        SER_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            load       = 1'b1;
            cnt_next   = '0;
            state_next = SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          out_valid = 1'b1;
          out_first = (cnt == '0);
          out_last  = (cnt == CNT_LAST);
          if (out_ready) begin
            if (cnt != CNT_LAST) begin
              shift    = 1'b1;
              cnt_next = cnt + CNT_WIDTH'(1);
            end else begin
              // Final bit leaves this cycle: reload with no bubble, or fall back to idle.
              in_ready = 1'b1;
              if (in_valid) begin
                load     = 1'b1;
                cnt_next = '0;
              end else begin
                state_next = SER_IDLE;
              end
            end
          end
        end
        default: state_next = SER_IDLE;
      endcase
    end
  end

  // Serial bit, held at 0 whenever no bit is being offered.
  always_comb begin
    out = out_valid & (|(shreg & OUT_MASK));
  end

endmodule

// File: tb/tb_serializer16.sv
// Self-checking bench: one LSB-first and one MSB-first instance against a word/bit-count model.
module tb_serializer16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] din       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        sout      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_first [2];
  logic        out_last  [2];

  serializer16 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in(din[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out(sout[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_first(out_first[0]), .out_last(out_last[0])
  );

  serializer16 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .in(din[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out(sout[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_first(out_first[1]), .out_last(out_last[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the word in flight and how many of its bits are still to go.
  logic [15:0] mw     [2];
  int          rem    [2];
  int          hs     [2];
  int          ones   [2];
  int          loads  [2];
  logic [15:0] rx     [2];   // bits shifted in arrival order (first bit ends up at [15])

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: compare every output with the model, advance the model, move to next negedge.
  task automatic tick(input string tag);
    logic ev, eo, er;
    int   pos;
    #1;
    for (int i = 0; i < 2; i++) begin
      ev  = !reset && (rem[i] > 0);
      pos = 16 - rem[i];
      eo  = 1'b0;
      if (ev) eo = (i == 0) ? mw[i][pos] : mw[i][15 - pos];
      er  = !reset && (rem[i] == 0 || (rem[i] == 1 && out_ready[i]));
      check($sformatf("%s.%0d valid", tag, i), 32'(out_valid[i]), 32'(ev));
      check($sformatf("%s.%0d out",   tag, i), 32'(sout[i]),      32'(eo));
      check($sformatf("%s.%0d first", tag, i), 32'(out_first[i]), 32'(ev && rem[i] == 16));
      check($sformatf("%s.%0d last",  tag, i), 32'(out_last[i]),  32'(ev && rem[i] == 1));
      check($sformatf("%s.%0d ready", tag, i), 32'(in_ready[i]),  32'(er));
      if (reset) begin
        rem[i] = 0;
      end else begin
        if (ev && out_ready[i]) begin
          hs[i]++;
          ones[i] += int'(sout[i]);
          rx[i]   = {rx[i][14:0], sout[i]};
          rem[i]--;
        end
        if (in_valid[i] && er) begin
          mw[i]  = din[i];
          rem[i] = 16;
          loads[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      din[i]       = 16'($urandom);
    end
  endtask

  int base_hs, base_ones, base_loads, guard;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; hs[i] = 0; ones[i] = 0; loads[i] = 0; rx[i] = '0; mw[i] = '0;
    end
    quiet_inputs();
    @(negedge clk);
    tick("reset");
    tick("reset");
    reset = 1'b0;
    tick("release");
    check("release idle lsb", 32'(in_ready[0]), 32'd1);

    // Basic LSB-first word.
    din[0] = 16'hA5C3; in_valid[0] = 1'b1;
    tick("lsb_load");
    in_valid[0] = 1'b0; din[0] = 16'($urandom);
    base_hs = hs[0]; rx[0] = '0;
    repeat (16) tick("lsb");
    check("lsb bit order", 32'(rx[0]), 32'h0000C3A5);
    check("lsb handshakes", 32'(hs[0] - base_hs), 32'd16);
    check("lsb done idle", 32'(out_valid[0]), 32'd0);

    // MSB-first word.
    din[1] = 16'h8001; in_valid[1] = 1'b1;
    tick("msb_load");
    in_valid[1] = 1'b0; din[1] = 16'($urandom);
    rx[1] = '0;
    repeat (16) tick("msb");
    check("msb bit order", 32'(rx[1]), 32'h00008001);
    check("msb done idle", 32'(out_valid[1]), 32'd0);

    // Backpressure: 3 stall cycles on bit 5, 2 on bit 16.
    din[0] = 16'hFFFF; in_valid[0] = 1'b1;
    tick("bp_load");
    in_valid[0] = 1'b0;
    base_hs = hs[0]; base_ones = ones[0];
    for (int c = 0; c < 21; c++) begin
      out_ready[0] = !((c >= 4 && c < 7) || (c >= 18 && c < 20));
      tick("bp");
    end
    out_ready[0] = 1'b1;
    check("bp handshakes", 32'(hs[0] - base_hs), 32'd16);
    check("bp ones", 32'(ones[0] - base_ones), 32'd16);
    check("bp done idle", 32'(out_valid[0]), 32'd0);

    // Back-to-back words with in_valid held high.
    din[0] = 16'h1234; in_valid[0] = 1'b1;
    base_loads = loads[0];
    tick("b2b_load");
    din[0] = 16'hFFFF;
    base_hs = hs[0];
    for (int c = 1; c <= 32; c++) begin
      if (c == 16) rx[0] = '0;
      tick("b2b");
      if (c == 16) in_valid[0] = 1'b0;
    end
    check("b2b loads", 32'(loads[0] - base_loads), 32'd2);
    check("b2b handshakes", 32'(hs[0] - base_hs), 32'd32);
    check("b2b second word", 32'(rx[0]), 32'h0000FFFF);
    check("b2b done idle", 32'(out_valid[0]), 32'd0);

    // Reset in mid-word.
    din[0] = 16'h00FF; in_valid[0] = 1'b1;
    tick("rmw_load");
    in_valid[0] = 1'b0;
    base_hs = hs[0]; guard = 0;
    while ((hs[0] - base_hs) < 6 && guard < 20) begin
      tick("rmw");
      guard++;
    end
    check("rmw six bits", 32'(hs[0] - base_hs), 32'd6);
    reset = 1'b1;
    #1;
    check("rmw reset out", 32'(sout[0]), 32'd0);
    check("rmw reset valid", 32'(out_valid[0]), 32'd0);
    check("rmw reset ready", 32'(in_ready[0]), 32'd0);
    tick("rmw_rst");
    tick("rmw_rst");
    reset = 1'b0;
    #1;
    check("rmw after ready", 32'(in_ready[0]), 32'd1);
    check("rmw after valid", 32'(out_valid[0]), 32'd0);
    din[0] = 16'h0001; in_valid[0] = 1'b1;
    tick("rmw_reload");
    in_valid[0] = 1'b0;
    rx[0] = '0;
    repeat (16) tick("rmw_word");
    check("rmw new word", 32'(rx[0]), 32'h00008000);

    // Load attempted while reset is held.
    reset = 1'b1;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    base_loads = loads[0] + loads[1];
    repeat (3) tick("lrst");
    reset = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    #1;
    check("lrst no word lsb", 32'(out_valid[0]), 32'd0);
    check("lrst no word msb", 32'(out_valid[1]), 32'd0);
    check("lrst model loads", 32'(loads[0] + loads[1] - base_loads), 32'd0);
    tick("lrst_after");

    // Randomized traffic on both instances with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(199) == 0);
      for (int i = 0; i < 2; i++) begin
        din[i]       = 16'($urandom);
        in_valid[i]  = ($urandom_range(2) != 0);
        out_ready[i] = ($urandom_range(3) != 0);
      end
      tick("rand");
    end
    reset = 1'b0;
    quiet_inputs();
    repeat (20) tick("drain");
    check("drain idle lsb", 32'(out_valid[0]), 32'd0);
    check("drain idle msb", 32'(out_valid[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
